// File: rtl/intersection_if.sv
// Request and lamp bundle shared by the intersection controller and its environment.
// The master side drives requests; the slave side (the controller) drives lamps.
interface intersection_if;
  logic       side_req;
  logic       ped_req;
  logic       emerg;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output side_req, ped_req, emerg,
    input  main_light, side_light, walk, phase
  );

  modport slave (
    input  side_req, ped_req, emerg,
    output main_light, side_light, walk, phase
  );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-road intersection phase scheduler.
// Main road rests on green; side road is served on a vehicle or pedestrian
// request after a minimum main green, with yellow and all-red clearance.
// An emergency preempt cuts side green short and holds the main road green.
// Lamps and walk are registered, loaded from the next-state decode, so they
// always match the registered phase and never depend on inputs combinationally.
// Every duration parameter must lie in 1..2^TW-1.
module intersection_ctrl #(
  parameter int unsigned TW           = 8,
  parameter int unsigned MIN_GREEN    = 20,
  parameter int unsigned SIDE_GREEN   = 12,
  parameter int unsigned YELLOW_TIME  = 4,
  parameter int unsigned ALL_RED_TIME = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  intersection_if.slave bus
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5,
    ILL_6  = 3'd6,
    ILL_7  = 3'd7
  } state_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;

  // Last count value of each timed state: a state of duration D exits at D-1.
  localparam logic [TW-1:0] MIN_G_LAST  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] SIDE_G_LAST = TW'(SIDE_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST    = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] RED_LAST    = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] CNT_ZERO    = {TW{1'b0}};
  localparam logic [TW-1:0] CNT_ONE     = {{(TW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          ped_pending_q, ped_pending_d;
  logic          walk_grant_q, walk_grant_d;
  logic [2:0]    main_light_q, side_light_q;
  logic          walk_q;
  logic          handover_s;

  // Main-road lamp for a given phase; anything unexpected shows red.
  function automatic logic [2:0] main_lamp(input state_e s);
    logic [2:0] l;
    case (s)
      MAIN_G:  l = LAMP_GREEN;
      MAIN_Y:  l = LAMP_YELLOW;
      default: l = LAMP_RED;
    endcase
    return l;
  endfunction

  // Side-road lamp for a given phase; anything unexpected shows red.
  function automatic logic [2:0] side_lamp(input state_e s);
    logic [2:0] l;
    case (s)
      SIDE_G:  l = LAMP_GREEN;
      SIDE_Y:  l = LAMP_YELLOW;
      default: l = LAMP_RED;
    endcase
    return l;
  endfunction

  // Next phase, phase timer and pedestrian bookkeeping.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ped_pending_d = ped_pending_q;
    walk_grant_d  = walk_grant_q;
    handover_s    = 1'b0;

    case (state_q)
      MAIN_G: begin
        if ((cnt_q == MIN_G_LAST) && (bus.side_req || ped_pending_q) && !bus.emerg) begin
          state_d = MAIN_Y;
        end else begin
          state_d = MAIN_G;
        end
      end
      MAIN_Y: begin
        if (cnt_q == YEL_LAST) begin
          state_d = RED_A;
        end else begin
          state_d = MAIN_Y;
        end
      end
      RED_A: begin
        if (cnt_q == RED_LAST) begin
          state_d    = SIDE_G;
          handover_s = 1'b1;
        end else begin
          state_d = RED_A;
        end
      end
      SIDE_G: begin
        // Preempt only shortens green; the clearance phases that follow run in full.
        if ((cnt_q == SIDE_G_LAST) || bus.emerg) begin
          state_d = SIDE_Y;
        end else begin
          state_d = SIDE_G;
        end
      end
      SIDE_Y: begin
        if (cnt_q == YEL_LAST) begin
          state_d = RED_B;
        end else begin
          state_d = SIDE_Y;
        end
      end
      RED_B: begin
        if (cnt_q == RED_LAST) begin
          state_d = MAIN_G;
        end else begin
          state_d = RED_B;
        end
      end
      default: begin
        // Corrupted encodings recover to main green with a fresh timer.
        state_d = MAIN_G;
      end
    endcase

    // Timer restarts on every phase change; main green parks at its minimum.
    if (state_d != state_q) begin
      cnt_d = CNT_ZERO;
    end else if ((state_q == MAIN_G) && (cnt_q == MIN_G_LAST)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Walk is granted for this side phase from what was pending before the edge.
    if (handover_s) begin
      walk_grant_d = ped_pending_q;
    end else begin
      walk_grant_d = walk_grant_q;
    end

    // A new press on the hand-over cycle survives for the next side phase.
    if (bus.ped_req) begin
      ped_pending_d = 1'b1;
    end else if (handover_s) begin
      ped_pending_d = 1'b0;
    end else begin
      ped_pending_d = ped_pending_q;
    end
  end

  // State, timer, pedestrian flags and registered lamp/walk outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MAIN_G;
      cnt_q         <= CNT_ZERO;
      ped_pending_q <= 1'b0;
      walk_grant_q  <= 1'b0;
      main_light_q  <= LAMP_GREEN;
      side_light_q  <= LAMP_RED;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      walk_grant_q  <= walk_grant_d;
      main_light_q  <= main_lamp(state_d);
      side_light_q  <= side_lamp(state_d);
      walk_q        <= walk_grant_d && (state_d == SIDE_G);
    end
  end

  assign bus.main_light = main_light_q;
  assign bus.side_light = side_light_q;
  assign bus.walk       = walk_q;
  assign bus.phase      = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed and randomised checks for intersection_ctrl with
// MIN_GREEN=10, SIDE_GREEN=8, YELLOW_TIME=3, ALL_RED_TIME=2.
// Cycle 0 is the first cycle after reset release; outputs are sampled at negedge.
module tb_intersection_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  intersection_if bus();

  intersection_ctrl #(
    .TW(8), .MIN_GREEN(10), .SIDE_GREEN(8), .YELLOW_TIME(3), .ALL_RED_TIME(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected lamps per phase code; codes 6/7 never expected.
  logic [2:0] exp_main [8] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
  logic [2:0] exp_side [8] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Phase for cycle c when side_req is held high: 10 G, 3 Y, 2 R, 8 G, 3 Y, 2 R.
  function automatic logic [2:0] cyc_phase(input int c);
    int t;
    t = c % 28;
    if (t < 10)      return 3'd0;
    else if (t < 13) return 3'd1;
    else if (t < 15) return 3'd2;
    else if (t < 23) return 3'd3;
    else if (t < 26) return 3'd4;
    else             return 3'd5;
  endfunction

  task automatic check_phase(input string tag, input logic [2:0] p);
    check_val(tag, 32'(bus.phase), 32'(p));
    check_val(tag, 32'({bus.main_light, bus.side_light}), 32'({exp_main[p], exp_side[p]}));
  endtask

  // Reset with quiet inputs, check outputs while held, release at a negedge.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.side_req = 1'b0;
    bus.ped_req  = 1'b0;
    bus.emerg    = 1'b0;
    #1;
    check_val("reset_out", 32'({bus.phase, bus.main_light, bus.side_light, bus.walk}),
              32'({3'd0, 3'b010, 3'b100, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] p;
    logic [2:0] prev;
    int         run;
    logic [4:0] ok;

    rst_n        = 1'b0;
    bus.side_req = 1'b0;
    bus.ped_req  = 1'b0;
    bus.emerg    = 1'b0;

    // Idle: main green held indefinitely.
    apply_reset();
    for (int c = 0; c < 50; c++) begin
      check_val("idle", 32'({bus.phase, bus.main_light, bus.side_light, bus.walk}),
                32'({3'd0, 3'b010, 3'b100, 1'b0}));
      @(negedge clk);
    end

    // side_req held: two full rounds.
    apply_reset();
    bus.side_req = 1'b1;
    for (int c = 0; c < 56; c++) begin
      check_phase("side_seq", cyc_phase(c));
      check_val("side_seq_walk", 32'(bus.walk), 32'(1'b0));
      @(negedge clk);
    end

    // One-cycle ped press at cycle 3: one service with walk, then main holds.
    apply_reset();
    for (int c = 0; c < 50; c++) begin
      bus.ped_req = (c == 3);
      p = (c < 28) ? cyc_phase(c) : 3'd0;
      check_phase("ped_seq", p);
      check_val("ped_walk", 32'(bus.walk), 32'((c >= 15) && (c <= 22)));
      @(negedge clk);
    end
    bus.ped_req = 1'b0;

    // Emergency on 3rd side-green cycle; main held while emerg, then resumes.
    apply_reset();
    bus.side_req = 1'b1;
    for (int c = 0; c < 58; c++) begin
      bus.emerg = (c >= 17) && (c < 50);
      if (c < 18)      p = cyc_phase(c);
      else if (c < 21) p = 3'd4;
      else if (c < 23) p = 3'd5;
      else if (c < 51) p = 3'd0;
      else if (c < 54) p = 3'd1;
      else if (c < 56) p = 3'd2;
      else             p = 3'd3;
      check_phase("emerg_seq", p);
      @(negedge clk);
    end
    bus.emerg = 1'b0;

    // Reset mid side-green with walk active.
    apply_reset();
    bus.side_req = 1'b0;
    for (int c = 0; c < 17; c++) begin
      bus.ped_req = (c == 0);
      @(negedge clk);
    end
    bus.ped_req = 1'b0;
    check_val("midrst_pre_phase", 32'(bus.phase), 32'(3'd3));
    check_val("midrst_pre_walk", 32'(bus.walk), 32'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out", 32'({bus.phase, bus.main_light, bus.side_light, bus.walk}),
              32'({3'd0, 3'b010, 3'b100, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    bus.side_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      check_phase("midrst_timer", cyc_phase(c));
      @(negedge clk);
    end

    // Random traffic: safety invariants and clearance durations every cycle.
    apply_reset();
    prev = bus.phase;
    run  = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 19) == 0) bus.side_req = ~bus.side_req;
      if ($urandom_range(0, 99) == 0) bus.emerg = ~bus.emerg;
      bus.ped_req = ($urandom_range(0, 49) == 0);
      ok[4] = ($countones(bus.main_light) == 1);
      ok[3] = ($countones(bus.side_light) == 1);
      ok[2] = (bus.main_light == 3'b100) || (bus.side_light == 3'b100);
      ok[1] = !bus.walk || (bus.phase == 3'd3);
      ok[0] = (bus.phase <= 3'd5);
      check_val("rand_invariants", 32'(ok), 32'(5'b11111));
      if (bus.phase == prev) begin
        run++;
      end else begin
        if ((prev == 3'd1) || (prev == 3'd4)) check_val("rand_yellow_len", 32'(run), 32'd3);
        if ((prev == 3'd2) || (prev == 3'd5)) check_val("rand_allred_len", 32'(run), 32'd2);
        prev = bus.phase;
        run  = 1;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/intersection_ctrl.md
Name: intersection_ctrl

Overview:
- Two-road intersection phase scheduler that drives a main road and a side road from one state machine.
- Each road gets its own 3-bit one-hot lamp bus: RED=100, GREEN=010, YELLOW=001.
- The main road rests on green. Service passes to the side road on a vehicle-sensor or pedestrian request, with guaranteed minimum green, yellow and all-red clearance times.
- An emergency-preempt input returns priority to the main road.

Parameters:
- TW, 8, timer width in bits; every duration below must be in 1..2^TW-1.
- MIN_GREEN, 20, minimum main-green cycles before a hand-over is allowed.
- SIDE_GREEN, 12, side-green duration in cycles.
- YELLOW_TIME, 4, yellow duration in cycles (both roads).
- ALL_RED_TIME, 2, all-red clearance duration in cycles.

Ports:
- clk  in  1  system clock; all durations are counted in clk cycles.
- rst_n  in  1  asynchronous active-low reset.
- side_req  in  1  side-road vehicle sensor, level-sensitive.
- ped_req  in  1  pedestrian button, pulse or level, sampled every cycle.
- emerg  in  1  emergency preempt, level-sensitive.
- main_light  out  3  main-road lamps, one-hot.
- side_light  out  3  side-road lamps, one-hot.
- walk  out  1  pedestrian walk signal for crossing the main road.
- phase  out  3  current state encoding, for debug.

Behaviour:
- States and encodings:
  - MAIN_G = 0
  - MAIN_Y = 1
  - RED_A = 2
  - SIDE_G = 3
  - SIDE_Y = 4
  - RED_B = 5
- Codes 6 and 7 are illegal; they go to MAIN_G on the next clk with the timer cleared.
- Reset (rst_n low, asynchronous): state=MAIN_G, cnt=0, ped_pending=0, walk_grant=0.
- Outputs during and immediately after reset: main_light=010, side_light=100, walk=0, phase=0.
- All outputs are decoded only from registered state; there are no combinational paths from inputs to outputs.
- Lamp decode by state:
  - MAIN_G: main=010, side=100.
  - MAIN_Y: main=001, side=100.
  - RED_A and RED_B: main=100, side=100.
  - SIDE_G: main=100, side=010.
  - SIDE_Y: main=100, side=001.
- Timer rules:
  - cnt (TW bits) clears to 0 on every state change and otherwise increments.
  - In MAIN_G, cnt saturates at MIN_GREEN-1.
  - A timed state with duration D lasts exactly D cycles.
- MAIN_G -> MAIN_Y when cnt==MIN_GREEN-1, (side_req or ped_pending) is true, and emerg is low. Otherwise MAIN_G holds indefinitely.
- MAIN_Y -> RED_A after YELLOW_TIME cycles.
- RED_A -> SIDE_G after ALL_RED_TIME cycles.
- SIDE_G -> SIDE_Y after SIDE_GREEN cycles, or on the first cycle emerg is sampled high (preempt). Preempt truncates green only; yellow and all-red always run their full length.
- SIDE_Y -> RED_B after YELLOW_TIME cycles.
- RED_B -> MAIN_G after ALL_RED_TIME cycles.
- emerg high in any state other than MAIN_G and SIDE_G has no effect on timing. The sequence completes normally to MAIN_G, which then holds while emerg stays high.
- Pedestrian request handling:
  - ped_pending sets on any cycle ped_req=1.
  - On the RED_A->SIDE_G transition, walk_grant <= ped_pending and ped_pending clears.
  - If ped_req=1 on that same cycle, set wins: ped_pending stays 1 and the request is served on the next cycle of the sequence.
- walk = walk_grant AND (state==SIDE_G). It deasserts on the same edge SIDE_G exits, including on preempt.
- side_req is not latched. If it drops before MIN_GREEN expires and no pedestrian request is pending, MAIN_G holds.
- Safety invariant: at no cycle are both main_light and side_light non-RED. Each lamp bus is always exactly one-hot.

Test Plan:
Parameters for all scenarios: MIN_GREEN=10, SIDE_GREEN=8, YELLOW_TIME=3, ALL_RED_TIME=2.
- Reset then idle 50 cycles with no requests -> main=010 and side=100 throughout, phase=0.
- side_req held high from cycle 0 after reset release:
  - MAIN_G lasts 10 cycles.
  - main=001 for 3 cycles, then all-red for 2 cycles.
  - side=010 for 8 cycles, side=001 for 3 cycles, all-red for 2 cycles.
  - Back to main=010; the cycle repeats because side_req is still high.
- Single-cycle ped_req at cycle 3 with side_req=0 -> hand-over at cycle 10. walk=1 for exactly the 8 SIDE_G cycles, and ped_pending is clear afterwards.
- emerg raised on the 3rd SIDE_G cycle -> side=001 on the next cycle, full 3-cycle yellow and 2-cycle all-red, then MAIN_G held while emerg=1, even with side_req=1.
- rst_n pulsed low mid-SIDE_G with walk=1 -> outputs immediately main=010, side=100, walk=0, phase=0; timer restarts from 0.
- Random side_req/ped_req/emerg for 10k cycles -> assertions hold every cycle:
  - Never both roads non-red.
  - Lamp buses always one-hot.
  - walk only in SIDE_G.
  - Every yellow lasts 3 cycles and every all-red lasts 2 cycles.
